// File: rtl/mtimer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mtimer_pkg
//  Description : Shared constants, types and helpers for the machine-mode
//                timer (address map, reset values, platform base address).
//  Revision    : 1.0 - initial release
// ============================================================================
package mtimer_pkg;

    typedef logic [1:0] mtimer_addr_t;

    // Word offsets inside the timer window
    localparam mtimer_addr_t MTIMER_MTIME_LO = 2'd0;
    localparam mtimer_addr_t MTIMER_MTIME_HI = 2'd1;
    localparam mtimer_addr_t MTIMER_CMP_LO   = 2'd2;
    localparam mtimer_addr_t MTIMER_CMP_HI   = 2'd3;

    // mtimecmp resets to the maximum so no interrupt fires out of reset
    localparam logic [63:0] MTIMER_CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Platform base address matched by the data-bus decoder
    localparam logic [31:0] MTIMER_BASE_ADDR = 32'h0200_0000;

    // Replace one 32-bit half of a 64-bit register
    function automatic logic [63:0] mtimer_set_half(input logic [63:0] v,
                                                    input logic        hi,
                                                    input logic [31:0] d);
        return hi ? {d, v[31:0]} : {v[63:32], d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtimer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mtimer_if
//  Description : Simple memory-mapped data bus between the core (master) and
//                the timer (slave). No wait states, one access per cycle.
//  Signals     : cs_n  - chip select, active low
//                we_n  - write enable, active low, qualified by cs_n
//                addr  - word offset within the timer window
//                wdata - write data
//                rdata - registered read data (one-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mtimer_if;
    import mtimer_pkg::*;

    logic         cs_n;
    logic         we_n;
    mtimer_addr_t addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;

    modport master (output cs_n, we_n, addr, wdata, input  rdata);
    modport slave  (input  cs_n, we_n, addr, wdata, output rdata);

endinterface
`default_nettype wire

// File: rtl/mtimer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : mtimer_prescaler
//  Description : Free-running divide-by-DIV counter producing a one-cycle
//                tick every DIV clocks. DIV=1 ticks every cycle.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset (count -> 0)
//                o_tick - high in the cycle the count equals DIV-1
//  Parameters  : DIV    - clocks per tick, 1..65535
//  Revision    : 1.0 - initial release
// ============================================================================
module mtimer_prescaler #(
    parameter int unsigned DIV = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      o_tick
);

    localparam logic [15:0] c_LAST = 16'(DIV - 1);

    logic [15:0] r_count;

    assign o_tick = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (o_tick) begin
            r_count <= 16'd0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : mtimer
//  Description : Machine-mode timer. 64-bit free-running mtime and 64-bit
//                mtimecmp, word-accessible over the simple data bus. Drives
//                the active-low timer interrupt ti_n while mtime >= mtimecmp.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - mtimer_if.slave (cs_n, we_n, addr, wdata, rdata)
//                ti_n - registered timer interrupt request, active low
//  Parameters  : DIV  - clocks per mtime increment, 1..65535
//  Options     : MTIMER_HI_LATCH_EN - reading mtime lo snapshots mtime hi
//                into a shadow that a following hi read returns, making a
//                lo-then-hi read pair atomic.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    mtimer_if.slave   bus,
    output logic      ti_n
);

    logic        w_tick;
    logic        w_wr;
    logic        w_rd;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [63:0] w_mtime_next;
    logic [63:0] w_cmp_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rd_val;

    mtimer_prescaler #(
        .DIV    (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    assign w_wr = ~bus.cs_n & ~bus.we_n;
    assign w_rd = ~bus.cs_n &  bus.we_n;

    // Next-state of both registers. A write to either mtime half replaces
    // the whole increment for that cycle, so no carry leaks into the other
    // half; the prescaler keeps running regardless.
    always_comb begin
        w_mtime_next = r_mtime + {63'd0, w_tick};
        w_cmp_next   = r_mtimecmp;
        if (w_wr) begin
            case (bus.addr)
                MTIMER_MTIME_LO,
                MTIMER_MTIME_HI: w_mtime_next = mtimer_set_half(r_mtime, bus.addr[0], bus.wdata);
                default:         w_cmp_next   = mtimer_set_half(r_mtimecmp, bus.addr[0], bus.wdata);
            endcase
        end
    end

`ifdef MTIMER_HI_LATCH_EN
    logic [31:0] r_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= 32'd0;
        end else if (w_rd && (bus.addr == MTIMER_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
        end
    end
`endif

    // Read mux works on pre-edge values, before this cycle's tick
    always_comb begin
        w_rd_val = 32'd0;
        case (bus.addr)
            MTIMER_MTIME_LO: w_rd_val = r_mtime[31:0];
`ifdef MTIMER_HI_LATCH_EN
            MTIMER_MTIME_HI: w_rd_val = r_shadow;
`else
            MTIMER_MTIME_HI: w_rd_val = r_mtime[63:32];
`endif
            MTIMER_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
            default:         w_rd_val = r_mtimecmp[63:32];
        endcase
    end

    // Compare on post-update values so ti_n moves in the same edge as the
    // write or tick that changes the condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= MTIMER_CMP_RST;
            r_rdata    <= 32'd0;
            ti_n       <= 1'b1;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_cmp_next;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            ti_n       <= ~(w_mtime_next >= w_cmp_next);
        end
    end

    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtimer
//  Description : Self-checking bench for mtimer. Two instances (DIV=1 and
//                DIV=4) share clk/rst and are compared every step against a
//                cycle-count based reference model. Honours
//                MTIMER_HI_LATCH_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtimer;
    import mtimer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtimer_if bif0 ();
    mtimer_if bif1 ();

    logic        cs_v [2];
    logic        we_v [2];
    logic [1:0]  ad_v [2];
    logic [31:0] wd_v [2];
    logic        ti_n0;
    logic        ti_n1;

    assign bif0.cs_n  = cs_v[0];
    assign bif0.we_n  = we_v[0];
    assign bif0.addr  = ad_v[0];
    assign bif0.wdata = wd_v[0];
    assign bif1.cs_n  = cs_v[1];
    assign bif1.we_n  = we_v[1];
    assign bif1.addr  = ad_v[1];
    assign bif1.wdata = wd_v[1];

    mtimer #(.DIV(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bif0.slave), .ti_n(ti_n0));
    mtimer #(.DIV(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1.slave), .ti_n(ti_n1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tick cycles follow purely from cycles since reset
    logic [63:0] m_mt  [2];
    logic [63:0] m_cmp [2];
    logic [31:0] m_rd  [2];
    logic        m_ti  [2];
    int          m_cyc [2];
`ifdef MTIMER_HI_LATCH_EN
    logic [31:0] m_sh  [2];
`endif

    function automatic int div_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] get_rd(input int u);
        return (u == 0) ? bif0.rdata : bif1.rdata;
    endfunction

    function automatic logic get_ti(input int u);
        return (u == 0) ? ti_n0 : ti_n1;
    endfunction

    task automatic model_edge(input int u);
        logic [63:0] nmt;
        logic [63:0] ncmp;
        logic        tick;
        if (rst) begin
            m_mt[u]  = 64'd0;
            m_cmp[u] = 64'hFFFF_FFFF_FFFF_FFFF;
            m_rd[u]  = 32'd0;
            m_ti[u]  = 1'b1;
            m_cyc[u] = 0;
`ifdef MTIMER_HI_LATCH_EN
            m_sh[u]  = 32'd0;
`endif
        end else begin
            tick = ((m_cyc[u] % div_of(u)) == (div_of(u) - 1));
            nmt  = m_mt[u] + (tick ? 64'd1 : 64'd0);
            ncmp = m_cmp[u];
            if (!cs_v[u] && !we_v[u]) begin
                case (ad_v[u])
                    2'd0:    nmt = {m_mt[u][63:32], wd_v[u]};
                    2'd1:    nmt = {wd_v[u], m_mt[u][31:0]};
                    2'd2:    ncmp[31:0] = wd_v[u];
                    default: ncmp[63:32] = wd_v[u];
                endcase
            end
            if (!cs_v[u] && we_v[u]) begin
                case (ad_v[u])
                    2'd0: begin
                        m_rd[u] = m_mt[u][31:0];
`ifdef MTIMER_HI_LATCH_EN
                        m_sh[u] = m_mt[u][63:32];
`endif
                    end
`ifdef MTIMER_HI_LATCH_EN
                    2'd1:    m_rd[u] = m_sh[u];
`else
                    2'd1:    m_rd[u] = m_mt[u][63:32];
`endif
                    2'd2:    m_rd[u] = m_cmp[u][31:0];
                    default: m_rd[u] = m_cmp[u][63:32];
                endcase
            end
            m_mt[u]  = nmt;
            m_cmp[u] = ncmp;
            m_ti[u]  = !(nmt >= ncmp);
            m_cyc[u] = m_cyc[u] + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic bus_set(input int u, input logic cs, input logic we,
                           input logic [1:0] a, input logic [31:0] d);
        cs_v[u] = cs;
        we_v[u] = we;
        ad_v[u] = a;
        wd_v[u] = d;
    endtask

    task automatic wr(input int u, input logic [1:0] a, input logic [31:0] d);
        bus_set(u, 1'b0, 1'b0, a, d);
        step();
        bus_set(u, 1'b1, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic rd(input int u, input logic [1:0] a);
        bus_set(u, 1'b0, 1'b1, a, 32'd0);
        step();
        bus_set(u, 1'b1, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if (get_rd(u) !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rdata u%0d: actual=%h expected=%h", u, get_rd(u), 32'd0);
            end
            n_tests++;
            if (get_ti(u) !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ti_n u%0d: actual=%b expected=1", u, get_ti(u));
            end
        end
        rst = 1'b0;
    endtask

    // Ten idle edges after release with DIV=1 -> mtime is 10 when read
    task automatic test_idle_count();
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (ti_n0 !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_ti_n cycle %0d: actual=%b expected=1", i, ti_n0);
            end
        end
        rd(0, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(0) !== 32'd10) begin
            n_fail++;
            $display("FAIL idle_mtime_lo: actual=%0d expected=10", get_rd(0));
        end
    endtask

    task automatic test_compare();
        int edge_n;
        int fall_edge;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr(1, MTIMER_CMP_HI, 32'd0);
        wr(1, MTIMER_CMP_LO, 32'd5);
        edge_n    = 2;
        fall_edge = -1;
        while (edge_n < 40 && fall_edge < 0) begin
            step();
            edge_n++;
            n_tests++;
            if (ti_n1 !== m_ti[1]) begin
                n_fail++;
                $display("FAIL cmp_ti_n edge %0d: actual=%b expected=%b", edge_n, ti_n1, m_ti[1]);
            end
            if (ti_n1 === 1'b0) fall_edge = edge_n;
        end
        n_tests++;
        if (fall_edge != 20) begin
            n_fail++;
            $display("FAIL cmp_fall_edge: actual=%0d expected=20", fall_edge);
        end
        wr(1, MTIMER_CMP_LO, 32'd100);
        n_tests++;
        if (ti_n1 !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_raise_ti_n: actual=%b expected=1", ti_n1);
        end
    endtask

    task automatic test_wrap();
        wr(0, MTIMER_CMP_HI, 32'd0);
        wr(0, MTIMER_CMP_LO, 32'd0);
        wr(0, MTIMER_MTIME_HI, 32'hFFFF_FFFF);
        wr(0, MTIMER_MTIME_LO, 32'hFFFF_FFFE);
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (ti_n0 !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_ti_n tick %0d: actual=%b expected=0", i, ti_n0);
            end
        end
        rd(0, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(0) !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_lo: actual=%h expected=0", get_rd(0));
        end
        rd(0, MTIMER_MTIME_HI);
        n_tests++;
        if (get_rd(0) !== 32'd0 || ti_n0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_hi: actual=%h ti_n=%b expected=0 ti_n=0", get_rd(0), ti_n0);
        end
    endtask

    task automatic test_carry();
        int k;
        wr(1, MTIMER_MTIME_HI, 32'd3);
        wr(1, MTIMER_MTIME_LO, 32'hFFFF_FFFF);
        k = 0;
        while (m_mt[1][31:0] == 32'hFFFF_FFFF && k < 8) begin
            step();
            k++;
        end
        rd(1, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(1) !== 32'd0) begin
            n_fail++;
            $display("FAIL carry_lo: actual=%h expected=0", get_rd(1));
        end
        rd(1, MTIMER_MTIME_HI);
        n_tests++;
        if (get_rd(1) !== 32'd4) begin
            n_fail++;
            $display("FAIL carry_hi: actual=%h expected=4", get_rd(1));
        end
    endtask

    // Write lo in the cycle the DIV=4 prescaler ticks
    task automatic test_collision();
        int k;
        wr(1, MTIMER_MTIME_HI, 32'h55);
        k = 0;
        while ((m_cyc[1] % 4) != 3 && k < 8) begin
            step();
            k++;
        end
        wr(1, MTIMER_MTIME_LO, 32'd7);
        rd(1, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(1) !== 32'd7) begin
            n_fail++;
            $display("FAIL collision_lo: actual=%0d expected=7", get_rd(1));
        end
        rd(1, MTIMER_MTIME_HI);
        n_tests++;
        if (get_rd(1) !== 32'h55) begin
            n_fail++;
            $display("FAIL collision_hi: actual=%h expected=55", get_rd(1));
        end
    endtask

    task automatic test_mid_reset();
        wr(1, MTIMER_MTIME_LO, 32'h1234);
        wr(1, MTIMER_CMP_HI, 32'd0);
        wr(1, MTIMER_CMP_LO, 32'd0);
        rd(1, MTIMER_MTIME_LO);
        n_tests++;
        if (ti_n1 !== 1'b0 || get_rd(1) !== m_rd[1]) begin
            n_fail++;
            $display("FAIL midrst_pre: actual=%h ti_n=%b expected=%h ti_n=0", get_rd(1), ti_n1, m_rd[1]);
        end
        rst = 1'b1;
        bus_set(1, 1'b0, 1'b1, MTIMER_CMP_LO, 32'd0);
        step();
        rst = 1'b0;
        bus_set(1, 1'b1, 1'b1, 2'd0, 32'd0);
        n_tests++;
        if (get_rd(1) !== 32'd0 || ti_n1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_out: actual=%h ti_n=%b expected=0 ti_n=1", get_rd(1), ti_n1);
        end
        rd(1, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(1) !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_mtime: actual=%h expected=0", get_rd(1));
        end
        rd(1, MTIMER_CMP_LO);
        n_tests++;
        if (get_rd(1) !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL midrst_cmp_lo: actual=%h expected=ffffffff", get_rd(1));
        end
        rd(1, MTIMER_CMP_HI);
        n_tests++;
        if (get_rd(1) !== 32'hFFFF_FFFF || ti_n1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_cmp_hi: actual=%h ti_n=%b expected=ffffffff ti_n=1", get_rd(1), ti_n1);
        end
    endtask

    // Lo-then-hi read across a carry: shadowed hi keeps the old value
    task automatic test_hi_read();
        logic [31:0] exp_hi;
`ifdef MTIMER_HI_LATCH_EN
        exp_hi = 32'd1;
`else
        exp_hi = 32'd2;
`endif
        wr(0, MTIMER_MTIME_HI, 32'd1);
        wr(0, MTIMER_MTIME_LO, 32'hFFFF_FFFF);
        rd(0, MTIMER_MTIME_LO);
        n_tests++;
        if (get_rd(0) !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL hiread_lo: actual=%h expected=ffffffff", get_rd(0));
        end
        rd(0, MTIMER_MTIME_HI);
        n_tests++;
        if (get_rd(0) !== exp_hi) begin
            n_fail++;
            $display("FAIL hiread_hi: actual=%h expected=%h", get_rd(0), exp_hi);
        end
    endtask

    task automatic test_random();
        int r;
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            for (int u = 0; u < 2; u++) begin
                r = int'($urandom_range(0, 9));
                case ($urandom_range(0, 7))
                    0:       d = $urandom;
                    1:       d = 32'hFFFF_FFFF;
                    default: d = $urandom_range(0, 40);
                endcase
                if (r < 3)      bus_set(u, 1'b0, 1'b0, 2'($urandom_range(0, 3)), d);
                else if (r < 6) bus_set(u, 1'b0, 1'b1, 2'($urandom_range(0, 3)), d);
                else            bus_set(u, 1'b1, 1'b1, 2'd0, d);
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if (get_rd(u) !== m_rd[u] || get_ti(u) !== m_ti[u]) begin
                    n_fail++;
                    $display("FAIL random u%0d cycle %0d: actual rdata=%h ti_n=%b expected rdata=%h ti_n=%b",
                             u, i, get_rd(u), get_ti(u), m_rd[u], m_ti[u]);
                end
            end
        end
        rst = 1'b0;
        bus_set(0, 1'b1, 1'b1, 2'd0, 32'd0);
        bus_set(1, 1'b1, 1'b1, 2'd0, 32'd0);
    endtask

    initial begin
        bus_set(0, 1'b1, 1'b1, 2'd0, 32'd0);
        bus_set(1, 1'b1, 1'b1, 2'd0, 32'd0);
        test_reset();
        test_idle_count();
        test_compare();
        test_wrap();
        test_carry();
        test_collision();
        test_mid_reset();
        test_hi_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mtimer.md
Name: mtimer

Overview:
- Machine-mode timer. It is the interrupt-producing end of the timer-interrupt line that the CSR unit consumes.
- Holds a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register, both word-accessible over the simple memory-mapped data bus.
- Drives the active-low timer-interrupt request ti_n whenever mtime >= mtimecmp.
- Sits on the data-memory bus beside RAM and feeds the core's ti input.

Parameters:
- DIV, 1: clk cycles per mtime increment (prescaler); legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- cs_n  input  1  chip select, active low.
- we_n  input  1  write enable, active low; qualified by cs_n.
- addr  input  2  word offset: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32].
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- ti_n  output  1  timer interrupt request, active low, registered.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at rising clk.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - prescaler count = 0.
  - rdata = 0.
  - ti_n = 1 (deasserted).
- rst wins over any concurrent bus access or tick.
- Prescaler:
  - Counts 0..DIV-1.
  - tick is asserted in the cycle the count equals DIV-1; the count then returns to 0.
  - DIV=1: tick every cycle.
- mtime:
  - On tick, mtime <= mtime + 1, full 64-bit.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0, with no flag.
- Write (cs_n=0, we_n=0): the addressed 32-bit half takes wdata at the clock edge.
  - Write to an mtime half in a tick cycle: the written half takes wdata, and the increment is discarded for the whole counter that cycle (no carry into the other half).
  - Prescaler is not disturbed by writes.
  - Writes to mtimecmp never affect mtime.
- Read (cs_n=0, we_n=1):
  - rdata <= addressed half, one cycle latency.
  - The value returned is the pre-edge value, i.e. before any tick in the same cycle.
  - rdata holds its last value when not reading.
  - A write cycle does not update rdata.
- Compare:
  - ti_n <= ~(mtime_next >= mtimecmp_next), unsigned 64-bit, evaluated on post-update values.
  - ti_n therefore changes in the same edge that makes the condition true or false, i.e. one cycle after the causing write or tick.
  - Level-sensitive, no latching. Software clears it only by raising mtimecmp or lowering mtime.
- Simultaneous events:
  - Write to mtimecmp and a tick in the same cycle: both apply.
  - The compare uses the new mtimecmp and the incremented mtime.
- Mid-operation reset: rst in any cycle, including a pending read, restores all reset values at that edge.
- Bus protocol:
  - No wait states.
  - Every access completes in one cycle.
  - Reads have no side effects unless HI_LATCH_EN is defined.

Optional Feature:
- Macro MTIMER_HI_LATCH_EN.
- Defined:
  - A read of addr 0 also copies mtime[63:32] (pre-edge) into a 32-bit shadow register.
  - A read of addr 1 returns the shadow, not the live value, so a lo-then-hi read sequence is atomic.
  - Shadow resets to 0.
  - A write to addr 1 updates live mtime only.
- Undefined:
  - No shadow register.
  - addr 1 returns live mtime[63:32].
  - Software must use the hi-lo-hi retry loop.

Decomposition:
- Shared package holds:
  - Address offset constants MTIMER_MTIME_LO=0, MTIMER_MTIME_HI=1, MTIMER_CMP_LO=2, MTIMER_CMP_HI=3.
  - Reset constant MTIMER_CMP_RST=64'hFFFF_FFFF_FFFF_FFFF.
  - The platform base address 32'h0200_0000 used by the bus decoder.
- One sub-module, mtimer_prescaler: counter with DIV parameter and tick output, reused later for a UART baud generator.
- Compare and register file stay in the top.

Test Plan:
- Reset, then idle 10 cycles with DIV=1:
  - Read addr 0 returns 10 (±access-cycle offset documented by the bench).
  - ti_n stays 1.
- DIV=4, write mtimecmp = {hi 0, lo 5}, mtime cleared:
  - ti_n falls to 0 exactly at the edge where mtime becomes 5, i.e. clk cycle 20 after release.
  - Write mtimecmp lo = 100 → ti_n returns to 1 one cycle later.
- Wrap-around: write mtime hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE, DIV=1:
  - After 2 ticks, mtime reads 0/0.
  - With mtimecmp = 0, ti_n = 0 throughout wrap.
- Carry into hi: mtime lo=32'hFFFF_FFFF, hi=3 → after 1 tick, hi reads 4 and lo reads 0.
- Collision: write mtime lo=7 in a tick cycle:
  - Lo reads 7, not 8.
  - Hi unchanged.
- Mid-operation reset: assert rst for 1 cycle during a read of addr 2:
  - rdata = 0.
  - mtime = 0.
  - mtimecmp = all-ones.
  - ti_n = 1 next cycle.
- With MTIMER_HI_LATCH_EN:
  - Setup: mtime = {hi 1, lo 32'hFFFF_FFFF}, DIV=1.
  - Read lo, then read hi one cycle later.
  - Hi returns 1 (shadow), while the live hi is 2.
